wb_queue: RTL
=============

Name: wb_queue

Overview:
- Writeback stage directly upstream of the CPU register file.
- Accepts completed results from the ALU and the load/store unit over valid/ready handshakes and buffers them in a small in-order FIFO.
- Drives the register file's write-side strobe interface: `rd_in`, `rd_value_in`, active-low `rd_write_in`, and a one-cycle `req_w` pulse.
- Exposes pending-write lookups so issue logic can stall on RAW hazards against queued results.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- rst  in  1  Reset; asynchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  Queue can accept the ALU result.
- alu_rd  in  5  ALU destination register.
- alu_value  in  32  ALU result.
- lsu_valid  in  1  Load result valid.
- lsu_ready  out  1  Queue can accept the load result.
- lsu_rd  in  5  Load destination register.
- lsu_value  in  32  Load data.
- rd_in  out  5  Register file write index.
- rd_value_in  out  32  Register file write data.
- rd_write_in  out  1  Register file write enable, active-low.
- req_w  out  1  Register file write strobe; the file samples on its rising edge.
- chk_rs1  in  5  Source index to check.
- chk_rs2  in  5  Source index to check.
- rs1_pending  out  1  A queued or in-flight entry targets chk_rs1.
- rs2_pending  out  1  A queued or in-flight entry targets chk_rs2.
- empty  out  1  No entries queued and no write in flight.
- count  out  CNT_W  Current occupancy.

Behaviour:
- **Reset values** (asynchronous on rst high): FIFO cleared, count=0, empty=1, req_w=0, rd_write_in=1, rd_in=0, rd_value_in=0, FSM=IDLE, pending outputs=0.
- **Handshake:** transfer occurs when valid && ready at a rising edge.
  - Ready is a function of registered occupancy and the other producer's valid only. It never depends on its own valid.
  - lsu_ready = (DEPTH-count >= 1).
  - alu_ready = (DEPTH-count >= 2) || (DEPTH-count >= 1 && !lsu_valid).
- **Ordering:** when both producers transfer in the same cycle, the LSU entry is written first, then the ALU entry. Writes reach the register file strictly in FIFO order.
- **x0 filter:** a transfer with rd=0 is accepted (handshake completes) but not enqueued. count and pending are unaffected.
- **Full:** no enqueue. Ready stays low until the HOLD-cycle pop lowers count. An enqueue and a pop in the same cycle are legal; count nets the two.
- **Drain FSM:**
  - IDLE: if FIFO non-empty, go to SETUP.
  - SETUP: drive rd_in/rd_value_in from head, rd_write_in=0, req_w=0.
  - STROBE: req_w=1, data and enable held.
  - HOLD: req_w=0, data and enable held; head popped at end of cycle. Next state is SETUP if more entries remain, otherwise IDLE.
  - On return to IDLE: rd_write_in=1.
- **Latency:** entry transferred at edge N gives SETUP in cycle N+1, req_w high in cycle N+2, pop at end of cycle N+3. Sustained throughput is one write per 3 cycles.
- **Pending lookup:** combinational compare of chk_rsX against every valid entry, including the head while in SETUP/STROBE/HOLD.
  - chk_rsX=0 always gives pending=0.
  - An entry stops contributing the cycle after its pop.
  - A same-cycle incoming transfer does not contribute until registered.
- **empty:** (count==0) && FSM==IDLE.
- **Reset mid-operation:**
  - req_w and rd_write_in are forced inactive immediately (asynchronously), with no glitch pulse.
  - Queued and in-flight writes are discarded.
  - The FSM restarts in IDLE on the first edge after rst deasserts.
- **Width rules:** data passes through unmodified. FIFO pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Package wb_pkg: typedef wb_entry_t {logic [4:0] rd; logic [31:0] value;}, enum wb_state_t {IDLE, SETUP, STROBE, HOLD}, constant REG_X0=5'd0.
- One sub-module, wb_fifo: parameterised synchronous FIFO.
  - Ports: two write ports, ordered write0-before-write1; one pop; full view of entries for the pending compare.
  - Top level holds the arbiter, x0 filter, drain FSM and lookups.

Test Plan:
1. Single write: lsu_valid with rd=5, value=0xDEADBEEF at edge 0 -> SETUP cycle 1; req_w=1 in cycle 2 with rd_in=5, rd_value_in=0xDEADBEEF, rd_write_in=0; empty=1 from cycle 4.
2. Dual enqueue: lsu (rd=3, 0x11) and alu (rd=4, 0x22) in the same cycle, empty queue -> both readies high; req_w pulses in cycles 2 and 5 carry rd 3 then rd 4.
3. Full/backpressure at DEPTH=4: 4 ALU entries queued -> alu_ready=lsu_ready=0. After the first HOLD pop, lsu_ready=1. With both valid and one slot free -> alu_ready=0, LSU accepted.
4. x0 filter: alu rd=0, value=0xFFFFFFFF -> alu_ready handshake completes; count stays 0; no req_w pulse ever.
5. Hazard lookup: queue rd=7 -> chk_rs1=7 gives rs1_pending=1 through HOLD and 0 the cycle after the pop. chk_rs2=0 always gives 0.
6. Reset mid-write: assert rst asynchronously during STROBE with 3 entries queued -> req_w=0 and rd_write_in=1 immediately; after release count=0, empty=1, no further strobes.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
package wb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wb_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO with two ordered write ports, one pop, and a full view of its
// entries so the owner can search every queued destination.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr0_en,
    input  wb_entry_t        wr0_data,
    input  logic             wr1_en,
    input  wb_entry_t        wr1_data,
    input  logic             pop,
    output wb_entry_t        head,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr1_ptr;

    // The second write lands behind the first only when the first is used.
    assign wr1_ptr = wr0_en ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign head    = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            entry_valid <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (wr0_en) begin
                mem[wr_ptr]         <= wr0_data;
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (wr1_en) begin
                mem[wr1_ptr]         <= wr1_data;
                entry_valid[wr1_ptr] <= 1'b1;
            end
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            count  <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and load results into an in-order FIFO and
// drains it into the register file through a SETUP/STROBE/HOLD write sequence.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_value,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_value,
    output logic [4:0]       rd_in,
    output logic [31:0]      rd_value_in,
    output logic             rd_write_in,
    output logic             req_w,
    input  logic [4:0]       chk_rs1,
    input  logic [4:0]       chk_rs2,
    output logic             rs1_pending,
    output logic             rs2_pending,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_state_t        state;
    wb_state_t        state_next;
    logic [CNT_W-1:0] free_slots;
    logic             lsu_push;
    logic             alu_push;
    wb_entry_t        lsu_entry;
    wb_entry_t        alu_entry;
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    // The load unit has priority for the last free slot, so the ALU only sees
    // ready on a single slot when no load is competing for it.
    assign free_slots = CNT_W'(DEPTH) - count;
    assign lsu_ready  = free_slots >= CNT_W'(1);
    assign alu_ready  = (free_slots >= CNT_W'(2)) || ((free_slots >= CNT_W'(1)) && !lsu_valid);

    assign lsu_push  = lsu_valid && lsu_ready && (lsu_rd != REG_X0);
    assign alu_push  = alu_valid && alu_ready && (alu_rd != REG_X0);
    assign lsu_entry = '{rd: lsu_rd, value: lsu_value};
    assign alu_entry = '{rd: alu_rd, value: alu_value};

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr0_en      (lsu_push || alu_push),
        .wr0_data    (lsu_push ? lsu_entry : alu_entry),
        .wr1_en      (lsu_push && alu_push),
        .wr1_data    (alu_entry),
        .pop         (state == HOLD),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid),
        .count       (count)
    );

    // An entry that arrives during HOLD is not counted yet, so it goes back
    // through IDLE and keeps the normal one-cycle enqueue-to-SETUP latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = (count > CNT_W'(1)) ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe and enable are flops so reset clears them without a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_w       <= 1'b0;
            rd_write_in <= 1'b1;
        end else begin
            state       <= state_next;
            req_w       <= (state_next == STROBE);
            rd_write_in <= (state_next == IDLE);
        end
    end

    assign rd_in       = (state != IDLE) ? head.rd : '0;
    assign rd_value_in = (state != IDLE) ? head.value : '0;
    assign empty       = (count == '0) && (state == IDLE);

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].rd == chk_rs1)) rs1_pending = 1'b1;
            if (entry_valid[i] && (entries[i].rd == chk_rs2)) rs2_pending = 1'b1;
        end
        if (chk_rs1 == REG_X0) rs1_pending = 1'b0;
        if (chk_rs2 == REG_X0) rs2_pending = 1'b0;
    end

endmodule
